// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left and parallel load,
// with a shift counter that pulses word_done on every WIDTH-th shift.
module univ_shift_reg #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] par_out,
    output logic             ser_out_lsb,
    output logic             ser_out_msb,
    output logic [CNT_W-1:0] bit_count,
    output logic             word_done
);

    localparam logic [1:0]       MODE_HOLD  = 2'b00;
    localparam logic [1:0]       MODE_RIGHT = 2'b01;
    localparam logic [1:0]       MODE_LEFT  = 2'b10;
    localparam logic [1:0]       MODE_LOAD  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             shift_s;
    logic             load_s;

    assign shift_s = enable && ((mode == MODE_RIGHT) || (mode == MODE_LEFT));
    assign load_s  = enable && (mode == MODE_LOAD);

    // Data path next state; any undecoded mode value behaves as hold.
    always_comb begin
        shreg_d = shreg_q;
        if (enable) begin
            case (mode)
                MODE_HOLD:  shreg_d = shreg_q;
                MODE_RIGHT: shreg_d = {ser_in_msb, shreg_q[WIDTH-1:1]};
                MODE_LEFT:  shreg_d = {shreg_q[WIDTH-2:0], ser_in_lsb};
                MODE_LOAD:  shreg_d = par_in;
                default:    shreg_d = shreg_q;
            endcase
        end else begin
            shreg_d = shreg_q;
        end
    end

    // Shift counter: both directions share one count; the wrapping shift raises word_done.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (load_s) begin
            cnt_d = CNT_ZERO;
        end else if (shift_s) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = CNT_ZERO;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg_q <= {WIDTH{1'b0}};
            cnt_q   <= CNT_ZERO;
            done_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign par_out     = shreg_q;
    assign ser_out_lsb = shreg_q[0];
    assign ser_out_msb = shreg_q[WIDTH-1];
    assign bit_count   = cnt_q;
    assign word_done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: a 4-bit and an 8-bit instance share
// control inputs; each step checks the instance under test.
module tb_univ_shift_reg;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [1:0] mode;
    logic       ser_in_msb;
    logic       ser_in_lsb;
    logic [7:0] par_in;

    logic [3:0] par4;
    logic       lsb4, msb4;
    logic [1:0] cnt4;
    logic       done4;
    logic [7:0] par8;
    logic       lsb8, msb8;
    logic [2:0] cnt8;
    logic       done8;

    int n_pass  = 0;
    int n_total = 0;

    univ_shift_reg #(.WIDTH(4)) u_dut4 (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode),
        .ser_in_msb(ser_in_msb), .ser_in_lsb(ser_in_lsb), .par_in(par_in[3:0]),
        .par_out(par4), .ser_out_lsb(lsb4), .ser_out_msb(msb4),
        .bit_count(cnt4), .word_done(done4)
    );

    univ_shift_reg #(.WIDTH(8)) u_dut8 (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode),
        .ser_in_msb(ser_in_msb), .ser_in_lsb(ser_in_lsb), .par_in(par_in),
        .par_out(par8), .ser_out_lsb(lsb8), .ser_out_msb(msb8),
        .bit_count(cnt8), .word_done(done8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check4(input string tag, input logic [3:0] p, input logic [1:0] c, input logic d);
        check({tag, ".par"},  {28'd0, par4},  {28'd0, p});
        check({tag, ".cnt"},  {30'd0, cnt4},  {30'd0, c});
        check({tag, ".done"}, {31'd0, done4}, {31'd0, d});
        check({tag, ".lsb"},  {31'd0, lsb4},  {31'd0, p[0]});
        check({tag, ".msb"},  {31'd0, msb4},  {31'd0, p[3]});
    endtask

    initial begin
        logic [7:0] v8;
        logic [3:0] v4;
        logic       b;

        // Reset held with random inputs and a running clock
        reset = 1'b0; enable = 1'b0; mode = 2'b00;
        ser_in_msb = 1'b0; ser_in_lsb = 1'b0; par_in = 8'h00;
        for (int i = 0; i < 3; i++) begin
            enable     = 1'($urandom_range(1, 0));
            mode       = 2'($urandom_range(3, 0));
            ser_in_msb = 1'($urandom_range(1, 0));
            ser_in_lsb = 1'($urandom_range(1, 0));
            par_in     = 8'($urandom_range(255, 0));
            tick();
        end
        check4("rst_hold", 4'b0000, 2'd0, 1'b0);
        check("rst_hold.par8", {24'd0, par8}, 32'd0);

        // Release, load, shift once, then reset mid-cycle
        enable = 1'b0; mode = 2'b00;
        #3 reset = 1'b1;
        tick();
        check4("rst_release", 4'b0000, 2'd0, 1'b0);
        enable = 1'b1; mode = 2'b11; par_in = 8'h0B;
        tick();
        check4("pre_rst_load", 4'b1011, 2'd0, 1'b0);
        mode = 2'b01; ser_in_msb = 1'b0;
        tick();
        check4("pre_rst_shift", 4'b0101, 2'd1, 1'b0);
        #2 reset = 1'b0;
        #1;
        check4("rst_async", 4'b0000, 2'd0, 1'b0);
        enable = 1'b0;
        #1 reset = 1'b1;
        tick();
        check4("rst_after", 4'b0000, 2'd0, 1'b0);

        // Serial-in right shift, 4 bits: 1,0,1,1
        enable = 1'b1; mode = 2'b01;
        ser_in_msb = 1'b1; tick(); check4("sr1", 4'b1000, 2'd1, 1'b0);
        ser_in_msb = 1'b0; tick(); check4("sr2", 4'b0100, 2'd2, 1'b0);
        ser_in_msb = 1'b1; tick(); check4("sr3", 4'b1010, 2'd3, 1'b0);
        ser_in_msb = 1'b1; tick(); check4("sr4", 4'b1101, 2'd0, 1'b1);
        mode = 2'b00; tick(); check4("sr_hold", 4'b1101, 2'd0, 1'b0);

        // Parallel-in, serial-out left on the 8-bit instance
        mode = 2'b11; par_in = 8'hA5; tick();
        check("pl_load.par8", {24'd0, par8}, 32'hA5);
        check("pl_load.cnt8", {29'd0, cnt8}, 32'd0);
        mode = 2'b10; ser_in_lsb = 1'b0;
        v8 = 8'hA5;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("pl_msb%0d", k), {31'd0, msb8}, {31'd0, v8[7]});
            tick();
            v8 = {v8[6:0], 1'b0};
            check($sformatf("pl_par%0d", k),  {24'd0, par8},  {24'd0, v8});
            check($sformatf("pl_cnt%0d", k),  {29'd0, cnt8},  32'(k % 8));
            check($sformatf("pl_done%0d", k), {31'd0, done8}, {31'd0, (k == 8)});
        end
        mode = 2'b00; tick();
        check("pl_after.done8", {31'd0, done8}, 32'd0);
        check("pl_after.par8",  {24'd0, par8},  32'd0);

        // Enable / hold gating
        mode = 2'b11; par_in = 8'h09; tick(); check4("eg_load", 4'b1001, 2'd0, 1'b0);
        mode = 2'b01; ser_in_msb = 1'b1;
        tick(); check4("eg_s1", 4'b1100, 2'd1, 1'b0);
        tick(); check4("eg_s2", 4'b1110, 2'd2, 1'b0);
        enable = 1'b0; ser_in_msb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); check4($sformatf("eg_en0_%0d", i), 4'b1110, 2'd2, 1'b0);
        end
        enable = 1'b1; mode = 2'b00;
        for (int i = 0; i < 2; i++) begin
            tick(); check4($sformatf("eg_hold%0d", i), 4'b1110, 2'd2, 1'b0);
        end
        mode = 2'b01;
        tick(); check4("eg_s3", 4'b0111, 2'd3, 1'b0);
        tick(); check4("eg_s4", 4'b0011, 2'd0, 1'b1);

        // Load mid-word clears the count
        ser_in_msb = 1'b0;
        tick(); check4("lm_s1", 4'b0001, 2'd1, 1'b0);
        tick(); check4("lm_s2", 4'b0000, 2'd2, 1'b0);
        tick(); check4("lm_s3", 4'b0000, 2'd3, 1'b0);
        mode = 2'b11; par_in = 8'h06;
        tick(); check4("lm_load", 4'b0110, 2'd0, 1'b0);
        mode = 2'b01; ser_in_msb = 1'b1;
        tick(); check4("lm_r1", 4'b1011, 2'd1, 1'b0);
        tick(); check4("lm_r2", 4'b1101, 2'd2, 1'b0);
        tick(); check4("lm_r3", 4'b1110, 2'd3, 1'b0);
        tick(); check4("lm_r4", 4'b1111, 2'd0, 1'b1);
        mode = 2'b11; par_in = 8'h06;
        tick(); check4("lm_load_after_done", 4'b0110, 2'd0, 1'b0);

        // Mixed directions share one count
        mode = 2'b01; ser_in_msb = 1'b1; tick(); check4("mx1", 4'b1011, 2'd1, 1'b0);
        mode = 2'b10; ser_in_lsb = 1'b0; tick(); check4("mx2", 4'b0110, 2'd2, 1'b0);
        mode = 2'b01; ser_in_msb = 1'b0; tick(); check4("mx3", 4'b0011, 2'd3, 1'b0);
        mode = 2'b10; ser_in_lsb = 1'b1; tick(); check4("mx4", 4'b0111, 2'd0, 1'b1);

        // Continuous streaming: word_done on shifts 4, 8 and 12
        mode = 2'b11; par_in = 8'h00; tick(); check4("st_load", 4'b0000, 2'd0, 1'b0);
        mode = 2'b01;
        v4 = 4'b0000;
        for (int i = 1; i <= 12; i++) begin
            b = 1'((i * 7 + 3) % 3 == 0);
            ser_in_msb = b;
            tick();
            v4 = {b, v4[3:1]};
            check4($sformatf("st%0d", i), v4, 2'(i % 4), (i % 4 == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register; next generation of the 4-bit serial-in right-shift register.
- Four modes, selected per cycle: hold, shift right, shift left, parallel load.
- Both serial outputs and the full parallel word are exposed.
- A shift counter flags each completed WIDTH-bit word, so the block serves as a serial-to-parallel or parallel-to-serial converter on lab serial links.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH) (minimum 1), width of the shift counter; derived, not overridden.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset (0 = reset)
- enable  input  1  1 = act on mode this edge; 0 = hold everything
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
- ser_in_msb  input  1  bit entering at bit WIDTH-1 on a right shift
- ser_in_lsb  input  1  bit entering at bit 0 on a left shift
- par_in  input  WIDTH  parallel load data
- par_out  output  WIDTH  current register contents
- ser_out_lsb  output  1  equals par_out[0]
- ser_out_msb  output  1  equals par_out[WIDTH-1]
- bit_count  output  CNT_W  shifts since the last load, reset or wrap
- word_done  output  1  one-cycle pulse when the WIDTH-th shift completes

Behaviour:
- Reset (reset=0), asynchronous: takes effect immediately regardless of clock.
  - Registered outputs: par_out=0, bit_count=0, word_done=0.
  - ser_out_lsb and ser_out_msb are combinational from par_out, so both read 0 during reset.
  - Reset asserted mid-word discards partial data and the count.
  - Deassertion is sampled normally; the first active edge after release is a normal cycle.
- Registered outputs (par_out, bit_count, word_done) update only on the rising clock edge. ser_out_lsb/ser_out_msb follow par_out combinationally, with no added delay.
- enable=0: register and bit_count hold; word_done=0 on the next edge.
- Mode 00 (hold): register and count hold; word_done=0.
- Mode 01 (shift right): reg <= {ser_in_msb, reg[WIDTH-1:1]}. Data moves toward bit 0 and leaves on ser_out_lsb.
- Mode 10 (shift left): reg <= {reg[WIDTH-2:0], ser_in_lsb}. Data moves toward bit WIDTH-1 and leaves on ser_out_msb.
- Mode 11 (load): reg <= par_in; bit_count <= 0; word_done <= 0.
- Counter, both shift directions:
  - bit_count != WIDTH-1: bit_count +1, word_done <= 0.
  - bit_count == WIDTH-1: bit_count wraps to 0, word_done <= 1 for exactly one cycle.
  - The wrapping shift's data is already in par_out in the same cycle word_done is high.
- Mixed directions within a word count together in one counter; there is no per-direction count.
- Back-to-back words: continuous shifting gives word_done every WIDTH cycles with no gap cycle.
- A load in the cycle after word_done is legal and clears the count normally.
- X on mode while enable=1 is illegal and need not be handled. The implementation treats any undecoded value as hold.
- Latency: one clock from inputs to par_out/bit_count/word_done.

Test Plan:
- Reset: WIDTH=4, hold reset=0 with random inputs and clock running, then drive reset=0 mid-cycle from a loaded state -> par_out=0000, bit_count=0, word_done=0 immediately, before any clock edge.
- Serial-in right: WIDTH=4, mode=01, enable=1, ser_in_msb=1,0,1,1 on four edges -> par_out 1000, 0100, 1010, 1101. bit_count 1, 2, 3, 0. word_done=1 only after the 4th edge.
- Parallel-in serial-out left: WIDTH=8, load par_in=0xA5, then mode=10 with ser_in_lsb=0 for 8 edges -> ser_out_msb sequence 1,0,1,0,0,1,0,1 (first value before the first shift). par_out=0x00 after 8 shifts; single word_done pulse.
- Enable/hold gating: WIDTH=4, after 2 right shifts toggle enable=0 for 3 cycles, then mode=00 for 2 cycles -> par_out and bit_count=2 unchanged, word_done stays 0. Resume shifting: word_done on the 2nd further shift.
- Load mid-word: WIDTH=4, shift 3 times, then load 0110 -> bit_count=0, no word_done. Four more shifts -> word_done pulses once.
- Continuous streaming: WIDTH=4, 12 consecutive right shifts -> word_done high on shifts 4, 8 and 12 only, each for exactly one cycle.
